// File: rtl/button_debounce.sv
// button_debounce
// Conditions a raw, asynchronous, bouncing board input into a clean level in
// the CLK domain, and emits one-cycle RISE/FALL pulses when that level flips.
//   I -> SYNC_STAGES-flop synchronizer -> S -> STABLE/CHECK FSM + N-bit counter
// A new level on S must disagree with O for 2^N+1 consecutive samples (the
// sample that enters CHECK plus 2^N counted ones) before it is committed, so O
// moves SYNC_STAGES + 2^N edges after I is first sampled at its new value.
// SYNC_STAGES must lie in 2..4; INIT is the level held by O and the
// synchronizer while RESETN is low.

module button_debounce #(
    parameter int N           = 16,
    parameter int SYNC_STAGES = 2,
    parameter bit INIT        = 1'b0
) (
    input  logic CLK,
    input  logic RESETN,
    input  logic I,
    output logic O,
    output logic RISE,
    output logic FALL,
    output logic BUSY
);

    typedef enum logic {
        STABLE = 1'b0,
        CHECK  = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    state_t                 state;
    logic [N-1:0]           count;

    // Only the last synchronizer stage is allowed to reach the FSM.
    assign s = sync[SYNC_STAGES-1];

    // Shift the raw pin through the synchronizer chain.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            sync <= {SYNC_STAGES{INIT}};
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop
            // samples the pre-edge value of its neighbour, giving a true shift.
            sync <= {sync[SYNC_STAGES-2:0], I};
        end
    end

    // Debounce FSM: qualify a disagreement between S and O for 2^N+1 samples,
    // then commit it to O and fire the matching edge pulse.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state <= STABLE;
            count <= '0;
            O     <= INIT;
            RISE  <= 1'b0;
            FALL  <= 1'b0;
        end else begin
            // NOTE: pulses default low every cycle and are only raised on the
            // commit cycle, which makes them exactly one clock wide.
            RISE <= 1'b0;
            FALL <= 1'b0;
            case (state)
                STABLE: begin
                    count <= '0;
                    if (s != O) begin
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if (s == O) begin
                        // Single agreeing sample: treat the change as a bounce.
                        state <= STABLE;
                        count <= '0;
                    end else if (&count) begin
                        // Terminal count reached: the new level has held long enough.
                        O     <= s;
                        RISE  <= s;
                        FALL  <= ~s;
                        state <= STABLE;
                        count <= '0;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
            endcase
        end
    end

    // BUSY is a pure decode of the FSM state, so it carries no path from I.
    assign BUSY = (state == CHECK);

endmodule

// File: tb/tb_button_debounce.sv
// tb_button_debounce
// Two debouncers (INIT=0 and INIT=1, N=3, SYNC_STAGES=2) driven by directed
// steps and random bouncing input, compared every cycle against a run-length
// reference model: the pin is delayed by the synchronizer depth, and the output
// flips once the delayed pin has disagreed with it for 2^N+1 consecutive edges.

module tb_button_debounce;

    localparam int N      = 3;
    localparam int SS     = 2;
    localparam int QUAL   = (1 << N) + 1;   // consecutive disagreeing samples to commit
    localparam int LAT    = SS + (1 << N) + 1; // edges from first sample to pulse, inclusive

    logic clk;
    logic rst_0, i_0, o_0, rise_0, fall_0, busy_0;
    logic rst_1, i_1, o_1, rise_1, fall_1, busy_1;

    button_debounce #(.N(N), .SYNC_STAGES(SS), .INIT(1'b0)) dut0 (
        .CLK(clk), .RESETN(rst_0), .I(i_0),
        .O(o_0), .RISE(rise_0), .FALL(fall_0), .BUSY(busy_0)
    );

    button_debounce #(.N(N), .SYNC_STAGES(SS), .INIT(1'b1)) dut1 (
        .CLK(clk), .RESETN(rst_1), .I(i_1),
        .O(o_1), .RISE(rise_1), .FALL(fall_1), .BUSY(busy_1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: pin delay line, committed level, pulses, and the
    // length of the current run of samples disagreeing with the level.
    typedef struct packed {
        logic [SS-1:0] sh;
        logic          o;
        logic          rise;
        logic          fall;
        int            run;
    } mdl_t;

    mdl_t m0, m1;
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    int   rc0 = 0, fc0 = 0, rc1 = 0, fc1 = 0;
    int   last0 = -1000, last1 = -1000;

    function automatic mdl_t mreset(input logic init);
        mdl_t r;
        r.sh   = {SS{init}};
        r.o    = init;
        r.rise = 1'b0;
        r.fall = 1'b0;
        r.run  = 0;
        return r;
    endfunction

    function automatic mdl_t mstep(input mdl_t m, input logic pin);
        mdl_t n;
        logic s;
        s      = m.sh[SS-1];
        n      = m;
        n.rise = 1'b0;
        n.fall = 1'b0;
        if (s != m.o) begin
            n.run = m.run + 1;
            if (n.run == QUAL) begin
                n.o    = s;
                n.rise = s;
                n.fall = ~s;
                n.run  = 0;
            end
        end else begin
            n.run = 0;
        end
        n.sh = {m.sh[SS-2:0], pin};
        return n;
    endfunction

    task automatic check(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_all();
        check("o0", o_0, m0.o);
        check("rise0", rise_0, m0.rise);
        check("fall0", fall_0, m0.fall);
        check("busy0", busy_0, m0.run != 0);
        check("o1", o_1, m1.o);
        check("rise1", rise_1, m1.rise);
        check("fall1", fall_1, m1.fall);
        check("busy1", busy_1, m1.run != 0);
    endtask

    // One clock: inputs already set by the caller, model advanced with the
    // pre-edge values, outputs sampled 1 time unit after the edge.
    task automatic cycle();
        @(posedge clk);
        m0 = rst_0 ? mstep(m0, i_0) : mreset(1'b0);
        m1 = rst_1 ? mstep(m1, i_1) : mreset(1'b1);
        cyc++;
        #1;
        check_all();
        if (rise_0 || fall_0) begin
            check("gap0", (cyc - last0) >= QUAL, 1'b1);
            last0 = cyc;
        end
        if (rise_1 || fall_1) begin
            check("gap1", (cyc - last1) >= QUAL, 1'b1);
            last1 = cyc;
        end
        rc0 += int'(rise_0);
        fc0 += int'(fall_0);
        rc1 += int'(rise_1);
        fc1 += int'(fall_1);
    endtask

    // Asynchronous reset of dut0 between edges; outputs must clear at once.
    task automatic async_reset0();
        #2;
        rst_0 = 1'b0;
        #1;
        m0 = mreset(1'b0);
        check("rst0_o", o_0, 1'b0);
        check("rst0_rise", rise_0, 1'b0);
        check("rst0_fall", fall_0, 1'b0);
        check("rst0_busy", busy_0, 1'b0);
    endtask

    task automatic async_reset1();
        #2;
        rst_1 = 1'b0;
        #1;
        m1 = mreset(1'b1);
        check("rst1_o", o_1, 1'b1);
        check("rst1_busy", busy_1, 1'b0);
    endtask

    // Clock with inputs held until the selected pulse appears (bounded).
    task automatic wait_pulse(input bit on_dut1, input bit want_rise, output int edges);
        edges = 0;
        for (int e = 1; e <= 30; e++) begin
            cycle();
            edges = e;
            if (!on_dut1 && (want_rise ? rise_0 : fall_0)) break;
            if (on_dut1 && (want_rise ? rise_1 : fall_1)) break;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int edges, b_edge, r_edge, rc_before, fc_before;
        int rem0, rem1;
        logic lvl0, lvl1;
        bit saw_busy;

        rst_0 = 1'b0; rst_1 = 1'b0; i_0 = 1'b0; i_1 = 1'b0;
        m0 = mreset(1'b0);
        m1 = mreset(1'b1);
        repeat (3) cycle();

        // 1: quiet input after release, nothing moves.
        rst_0 = 1'b1;
        repeat (20) cycle();
        check_int("t1_rises", rc0, 0);
        check_int("t1_falls", fc0, 0);

        // 2: clean 0->1 step; BUSY after the 3rd edge, RISE on the 11th.
        i_0 = 1'b1;
        b_edge = 0; r_edge = 0;
        for (int e = 1; e <= 30; e++) begin
            cycle();
            if (busy_0 && b_edge == 0) b_edge = e;
            if (rise_0) begin r_edge = e; break; end
        end
        check_int("t2_busy_edge", b_edge, SS + 1);
        check_int("t2_rise_edge", r_edge, LAT);
        cycle();
        check("t2_rise_one_cycle", rise_0, 1'b0);
        check_int("t2_falls", fc0, 0);

        // 3: 5-cycle low glitch is rejected, then a real 1->0 change.
        fc_before = fc0;
        saw_busy = 1'b0;
        i_0 = 1'b0;
        repeat (5) begin cycle(); if (busy_0) saw_busy = 1'b1; end
        i_0 = 1'b1;
        repeat (6) cycle();
        check("t3_busy_seen", saw_busy, 1'b1);
        check("t3_busy_clear", busy_0, 1'b0);
        check("t3_o_held", o_0, 1'b1);
        check_int("t3_no_fall", fc0, fc_before);
        i_0 = 1'b0;
        wait_pulse(1'b0, 1'b0, edges);
        check_int("t3_fall_edge", edges, LAT);

        // 4: toggling every 3 cycles never qualifies; final hold high does.
        rc_before = rc0;
        for (int c = 0; c < 50; c++) begin
            i_0 = ((c / 3) % 2) == 1;
            cycle();
        end
        check_int("t4_no_rise_toggle", rc0, rc_before);
        i_0 = 1'b1;
        wait_pulse(1'b0, 1'b1, edges);
        check_int("t4_rise_edge", edges, LAT);
        check_int("t4_one_rise", rc0 - rc_before, 1);

        // 5: reset while qualifying a 1->0 change (count 5), then I held 1.
        i_0 = 1'b0;
        repeat (SS + 6) cycle();
        check("t5_busy_before", busy_0, 1'b1);
        async_reset0();
        i_0 = 1'b1;
        repeat (2) cycle();
        rst_0 = 1'b1;
        wait_pulse(1'b0, 1'b1, edges);
        check_int("t5_rise_edge", edges, LAT);

        // 5b: reset on the cycle before a pending FALL drops it.
        fc_before = fc0;
        i_0 = 1'b0;
        repeat (LAT - 1) cycle();
        async_reset0();
        cycle();
        rst_0 = 1'b1;
        repeat (15) cycle();
        check_int("t5b_fall_dropped", fc0, fc_before);

        // 6: INIT=1 instance released with I=0 falls on the 11th edge.
        i_1 = 1'b0;
        rst_1 = 1'b1;
        cycle();
        check("t6_o_after_release", o_1, 1'b1);
        wait_pulse(1'b1, 1'b0, edges);
        check_int("t6_fall_edge", edges, LAT - 1);
        check_int("t6_no_rise", rc1, 0);

        // Random bouncing segments on both instances, with rare resets.
        rem0 = 0; rem1 = 0; lvl0 = 1'b0; lvl1 = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (rem0 == 0) begin
                lvl0 = 1'($urandom_range(0, 1));
                rem0 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(9, 20)) : int'($urandom_range(1, 6));
            end
            if (rem1 == 0) begin
                lvl1 = 1'($urandom_range(0, 1));
                rem1 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(9, 20)) : int'($urandom_range(1, 6));
            end
            i_0 = lvl0; rem0--;
            i_1 = lvl1; rem1--;
            rst_0 = 1'b1;
            rst_1 = 1'b1;
            if ($urandom_range(0, 399) == 0) async_reset0();
            if ($urandom_range(0, 399) == 0) async_reset1();
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
